ipf_seq: RTL
============

IPF_SEQ -- requirements
Module: ipf_seq

Interface
REQ-001 Parameter WBEATS, default 3: 64-bit weight beats per tile. 144 weight bits are padded to 192.
REQ-002 Parameter ROWS, default 8: 64-bit image rows per tile.
REQ-003 Parameter KERNELS, default 2: 72-bit 3x3 kernels per tile.
REQ-004 Parameter SHIFTS, default 8: compute cycles per kernel, which is the row-rotation length.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle job request.
REQ-008 n_tiles  in  8  tile count, sampled when start is accepted.
REQ-009 src_i_data, src_i_valid, src_i_ready  in/in/out  64/1/1  image source handshake.
REQ-010 src_w_data, src_w_valid, src_w_ready  in/in/out  64/1/1  weight source handshake.
REQ-011 i_data, i_valid  out  64/1  image beat to the engine.
REQ-012 w_data, w_valid  out  64/1  weight beat to the engine.
REQ-013 ctrl  out  2  engine command: 0=END, 1=START, 2=HOLD, 3=RUN (no-op).
REQ-014 res_valid  in  1  engine result strobe.
REQ-015 busy, done, res_err  out  1/1/1  status.
REQ-016 tile_cnt  out  8  tiles completed in the current job.

Function
REQ-017 States SHALL be IDLE, LOADW, LOADI, RUN, FIN and DONE.
REQ-018 IDLE: ctrl=HOLD, busy=0; start with n_tiles!=0 latches n_tiles, clears tile_cnt and moves to LOADW.
REQ-019 IDLE: start with n_tiles==0 pulses done for 1 cycle and stays in IDLE.
REQ-020 LOADW: src_w_ready=1 and ctrl=HOLD; w_valid=src_w_valid and w_data=src_w_data combinationally; the state moves to LOADI after WBEATS accepted beats.
REQ-021 LOADI: src_i_ready=1 and ctrl=HOLD; image beats are forwarded the same way; the state moves to RUN after ROWS accepted beats.
REQ-022 i_valid and w_valid SHALL never be high in the same cycle; both SHALL be 0 outside LOADI and LOADW respectively.
REQ-023 RUN uses counter rc, which starts at 0 on entry.
REQ-024 RUN ctrl: rc=0 gives START; rc=1..KERNELS*SHIFTS-1 gives RUN; rc=KERNELS*SHIFTS gives HOLD.
REQ-025 The RUN state SHALL last KERNELS*SHIFTS+1 cycles, which is 17 at defaults.
REQ-026 On the HOLD cycle tile_cnt increments; the next state is FIN if the new tile_cnt equals the latched n_tiles, otherwise LOADW.
REQ-027 FIN: ctrl=END and done=1 for exactly 1 cycle, then the state moves to DONE.
REQ-028 DONE: ctrl=END and busy=0; start is ignored; only rst leaves DONE, because engine FINISH is terminal.
REQ-029 busy=1 in LOADW, LOADI, RUN and FIN.
REQ-030 Source data presented outside the matching load state SHALL NOT be accepted (ready=0).
REQ-031 Beat and rc counters SHALL saturate at their terminal count and never wrap.
REQ-032 tile_cnt SHALL wrap modulo 256 only when n_tiles=0 is impossible, which it is, so it never exceeds n_tiles.
REQ-033 start asserted while busy or in DONE SHALL be ignored and SHALL NOT change the latched n_tiles.

Reset
REQ-034 rst SHALL force state=IDLE, all counters=0, tile_cnt=0, res_err=0, done=0, ctrl=HOLD, and all ready/valid outputs=0.
REQ-035 rst mid-job SHALL abandon the tile with no done pulse; the engine is reset by the same rst.

Configuration
REQ-036 Macro IPF_SEQ_ERRCHK_EN defined: a res_valid counter clears on RUN entry and counts res_valid cycles in RUN, including the HOLD cycle.
REQ-037 With IPF_SEQ_ERRCHK_EN defined: at the HOLD cycle, a count (including that cycle) !=KERNELS*SHIFTS sets res_err, which is sticky until the next accepted start or rst.
REQ-038 Macro IPF_SEQ_ERRCHK_EN undefined: res_err SHALL be constant 0 and no counter is present.

Verification
REQ-039 Defaults, n_tiles=1, sources always valid -> 3 w_valid, 8 i_valid, then START, 15 RUN, HOLD, 1-cycle done, ctrl=END held, tile_cnt=1.
REQ-040 n_tiles=3 -> three LOADW/LOADI/RUN sequences with tile_cnt 1,2,3, then a single done pulse.
REQ-041 src_i_valid toggling every other cycle -> exactly 8 beats forwarded, i_valid never high together with w_valid, and RUN starts only after the 8th beat.
REQ-042 start with n_tiles=0 -> done pulse next cycle, busy stays 0, ctrl stays HOLD.
REQ-043 rst asserted during RUN at rc=5 -> IDLE, ctrl=HOLD and tile_cnt=0 immediately; a new start runs a clean job.
REQ-044 With IPF_SEQ_ERRCHK_EN, res_valid held low during RUN -> res_err=1 at the HOLD cycle; it clears on the next start.

Source files
------------

// File: rtl/ipf_seq.sv
// ipf_seq: tile sequencer for the image/weight engine. Loads weights, then image rows,
// then runs the kernel/shift schedule for each tile. Optional result check: IPF_SEQ_ERRCHK_EN.
module ipf_seq #(
    parameter int WBEATS  = 3,
    parameter int ROWS    = 8,
    parameter int KERNELS = 2,
    parameter int SHIFTS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  n_tiles,
    input  logic [63:0] src_i_data,
    input  logic        src_i_valid,
    output logic        src_i_ready,
    input  logic [63:0] src_w_data,
    input  logic        src_w_valid,
    output logic        src_w_ready,
    output logic [63:0] i_data,
    output logic        i_valid,
    output logic [63:0] w_data,
    output logic        w_valid,
    output logic [1:0]  ctrl,
    input  logic        res_valid,
    output logic        busy,
    output logic        done,
    output logic        res_err,
    output logic [7:0]  tile_cnt
);

    localparam int RUN_LAST = KERNELS * SHIFTS;
    localparam int RC_W     = $clog2(RUN_LAST + 1);
    localparam int BEAT_MAX = (WBEATS > ROWS) ? WBEATS : ROWS;
    localparam int BEAT_W   = $clog2(BEAT_MAX + 1);

    localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RUN_LAST);
    localparam logic [BEAT_W-1:0] W_LAST  = BEAT_W'(WBEATS - 1);
    localparam logic [BEAT_W-1:0] I_LAST  = BEAT_W'(ROWS - 1);

    localparam logic [1:0] C_END   = 2'd0;
    localparam logic [1:0] C_START = 2'd1;
    localparam logic [1:0] C_HOLD  = 2'd2;
    localparam logic [1:0] C_RUN   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_LOADI,
        S_RUN,
        S_FIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [7:0]        n_tiles_q, n_tiles_d;
    logic [7:0]        tile_cnt_q, tile_cnt_d;
    logic [7:0]        tile_next;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Beats pass straight through; only the load state's ready gates acceptance.
    assign src_w_ready = (state_q == S_LOADW);
    assign src_i_ready = (state_q == S_LOADI);
    assign w_valid     = src_w_ready && src_w_valid;
    assign i_valid     = src_i_ready && src_i_valid;
    assign w_data      = src_w_data;
    assign i_data      = src_i_data;

    assign tile_next = tile_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rc_d       = rc_q;
        n_tiles_d  = n_tiles_q;
        tile_cnt_d = tile_cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_tiles != 8'd0) begin
                        n_tiles_d  = n_tiles;
                        tile_cnt_d = 8'd0;
                        beat_d     = '0;
                        state_d    = S_LOADW;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOADW: begin
                if (w_valid) begin
                    if (beat_q == W_LAST) begin
                        beat_d  = '0;
                        state_d = S_LOADI;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_LOADI: begin
                if (i_valid) begin
                    if (beat_q == I_LAST) begin
                        beat_d  = '0;
                        rc_d    = '0;
                        state_d = S_RUN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (rc_q == RC_LAST) begin
                    tile_cnt_d = tile_next;
                    rc_d       = '0;
                    state_d    = (tile_next == n_tiles_q) ? S_FIN : S_LOADW;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        unique case (state_d)
            S_RUN: begin
                if (rc_d == '0)          ctrl_d = C_START;
                else if (rc_d == RC_LAST) ctrl_d = C_HOLD;
                else                      ctrl_d = C_RUN;
            end
            S_FIN, S_DONE: ctrl_d = C_END;
            default:       ctrl_d = C_HOLD;
        endcase
        busy_d = (state_d == S_LOADW) || (state_d == S_LOADI) ||
                 (state_d == S_RUN)   || (state_d == S_FIN);
        done_d = done_d || (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            rc_q       <= '0;
            n_tiles_q  <= 8'd0;
            tile_cnt_q <= 8'd0;
            ctrl_q     <= C_HOLD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rc_q       <= rc_d;
            n_tiles_q  <= n_tiles_d;
            tile_cnt_q <= tile_cnt_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ctrl     = ctrl_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tile_cnt = tile_cnt_q;

`ifdef IPF_SEQ_ERRCHK_EN
    localparam int RES_W = $clog2(RUN_LAST + 2);

    logic [RES_W-1:0] res_cnt_q, res_cnt_d, res_cnt_inc;
    logic             res_err_q, res_err_d;

    // The HOLD cycle's own strobe is part of the count it is judged on.
    always_comb begin
        res_cnt_d   = res_cnt_q;
        res_err_d   = res_err_q;
        res_cnt_inc = (res_valid && (res_cnt_q != '1)) ? res_cnt_q + 1'b1 : res_cnt_q;
        if (state_q == S_IDLE && start) begin
            res_err_d = 1'b0;
        end
        if (state_q == S_LOADI && i_valid && beat_q == I_LAST) begin
            res_cnt_d = '0;
        end
        if (state_q == S_RUN) begin
            res_cnt_d = res_cnt_inc;
            if (rc_q == RC_LAST && res_cnt_inc != RES_W'(RUN_LAST)) begin
                res_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            res_cnt_q <= res_cnt_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    logic unused_res_valid;
    assign unused_res_valid = res_valid;
    assign res_err          = 1'b0;
`endif

endmodule
